// File: rtl/vdp18_pkg.sv
// vdp18_pkg: shared VDP types and constants (slot owners, CPU scheduler states).
package vdp18_pkg;
    typedef enum logic [3:0] {
        AC_NONE, AC_PNT, AC_PCT, AC_PGT, AC_STST, AC_SATY,
        AC_SATX, AC_SATN, AC_SATC, AC_SPTH, AC_SPTL, AC_CPU
    } access_t;
    typedef enum logic [1:0] {IDLE, PEND, ACCESS} cpu_sched_state_t;
    localparam int VRAM_AW_C = 14;
endpackage

// File: rtl/vdp18_cpu_vram_sched_if.sv
// vdp18_cpu_vram_sched_if: CPU I/O block <-> VRAM scheduler request/ack bus.
interface vdp18_cpu_vram_sched_if;
    import vdp18_pkg::*;
    logic                 cpu_rd_req_i;
    logic                 cpu_wr_req_i;
    logic [VRAM_AW_C-1:0] cpu_addr_i;
    logic [7:0]           cpu_wdata_i;
    logic                 cpu_busy_o;
    logic                 cpu_ack_o;
    logic [7:0]           cpu_rdata_o;
    modport master (output cpu_rd_req_i, cpu_wr_req_i, cpu_addr_i, cpu_wdata_i,
                    input cpu_busy_o, cpu_ack_o, cpu_rdata_o);
    modport slave (input cpu_rd_req_i, cpu_wr_req_i, cpu_addr_i, cpu_wdata_i,
                   output cpu_busy_o, cpu_ack_o, cpu_rdata_o);
endinterface

// File: rtl/vdp18_wait_mon.sv
// vdp18_wait_mon: saturating slot-wait counter, max-wait tracker and sticky starve flag.
module vdp18_wait_mon #(
    parameter int WAIT_LIMIT = 32
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       inc_i,
    input  logic       done_i,
    input  logic       clr_i,
    output logic       starve_o,
    output logic [7:0] wait_max_o
);
    localparam logic [7:0] LIMIT_C = 8'(WAIT_LIMIT);
    logic [7:0] cnt;
    logic [7:0] cnt_inc;
    assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    // clear wins over both a simultaneous starve set and a max update
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt        <= '0;
            starve_o   <= 1'b0;
            wait_max_o <= '0;
        end else begin
            cnt        <= done_i ? '0 : inc_i ? cnt_inc : cnt;
            starve_o   <= !clr_i && (starve_o || (inc_i && cnt_inc >= LIMIT_C));
            wait_max_o <= clr_i ? '0 : (done_i && cnt > wait_max_o) ? cnt : wait_max_o;
        end
    end
endmodule

// File: rtl/vdp18_cpu_vram_sched.sv
// vdp18_cpu_vram_sched: places one pending CPU VRAM access into the next AC_CPU slot
// and muxes the VRAM port between video fetch and the CPU.
module vdp18_cpu_vram_sched
    import vdp18_pkg::*;
#(
    parameter int WAIT_LIMIT = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 clk_en_acc_i,
    input  access_t              access_type_i,
    input  logic [VRAM_AW_C-1:0] vid_addr_i,
    vdp18_cpu_vram_sched_if.slave cpu,
    output logic [VRAM_AW_C-1:0] vram_a_o,
    output logic [7:0]           vram_d_o,
    output logic                 vram_we_o,
    input  logic [7:0]           vram_d_i,
    input  logic                 starve_clr_i,
    output logic                 starve_o,
    output logic [7:0]           wait_max_o
);
    cpu_sched_state_t     state;
    logic [VRAM_AW_C-1:0] addr;
    logic                 wr;
    logic                 done;
    logic                 inc;
    assign done           = state == ACCESS && clk_en_acc_i;
    assign inc            = state == PEND && clk_en_acc_i && access_type_i != AC_CPU;
    assign cpu.cpu_ack_o  = done;
    assign cpu.cpu_busy_o = state != IDLE;
    assign vram_a_o       = state == ACCESS ? addr : vid_addr_i;
    // write wins over a simultaneous read; requests while busy are dropped
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state           <= IDLE;
            addr            <= '0;
            wr              <= 1'b0;
            vram_d_o        <= '0;
            vram_we_o       <= 1'b0;
            cpu.cpu_rdata_o <= '0;
        end else begin
            case (state)
                IDLE: if (cpu.cpu_rd_req_i || cpu.cpu_wr_req_i) begin
                    addr     <= cpu.cpu_addr_i;
                    vram_d_o <= cpu.cpu_wdata_i;
                    wr       <= cpu.cpu_wr_req_i;
                    state    <= PEND;
                end
                PEND: if (clk_en_acc_i && access_type_i == AC_CPU) begin
                    vram_we_o <= wr;
                    state     <= ACCESS;
                end
                ACCESS: if (clk_en_acc_i) begin
                    if (!wr) cpu.cpu_rdata_o <= vram_d_i;
                    vram_we_o <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    vdp18_wait_mon #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_mon (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .inc_i      (inc),
        .done_i     (done),
        .clr_i      (starve_clr_i),
        .starve_o   (starve_o),
        .wait_max_o (wait_max_o)
    );
endmodule

// File: doc/vdp18_cpu_vram_sched.md
Name: vdp18_cpu_vram_sched

Overview:
- Schedules CPU VRAM reads and writes into the free VRAM slots left by the timing controller, which marks them AC_CPU on access_type_i.
- Holds one pending CPU request and issues it in the next free slot. Drives the VRAM address/data/write-enable mux, returns read data and acknowledges completion.
- Sits between the CPU I/O block, the timing controller and the external VRAM port.
- Also tracks how many slots a request waited, for starvation diagnostics.

Parameters:
- WAIT_LIMIT, 32: acc-slot wait count at which starve_o is set; valid range 1..254.

Ports:
- clk_i  in  1  system clock
- reset_n_i  in  1  async active-low reset
- clk_en_acc_i  in  1  access-slot enable (one clk_i pulse per VRAM slot)
- access_type_i  in  access_t  current slot owner from the timing controller
- vid_addr_i  in  14  video-fetch VRAM address
- cpu_rd_req_i  in  1  CPU read request, single-cycle pulse
- cpu_wr_req_i  in  1  CPU write request, single-cycle pulse
- cpu_addr_i  in  14  CPU VRAM address
- cpu_wdata_i  in  8  CPU write data
- cpu_busy_o  out  1  request pending or in flight
- cpu_ack_o  out  1  one-clk pulse on completion
- cpu_rdata_o  out  8  last read data
- vram_a_o  out  14  VRAM address
- vram_d_o  out  8  VRAM write data
- vram_we_o  out  1  VRAM write enable
- vram_d_i  in  8  VRAM read data
- starve_clr_i  in  1  clears starve_o and wait_max_o
- starve_o  out  1  sticky: a request waited >= WAIT_LIMIT slots
- wait_max_o  out  8  maximum slots waited since clear, saturating

Behaviour:
- Reset (async, reset_n_i=0):
  - state=IDLE; cpu_busy_o=0, cpu_ack_o=0, cpu_rdata_o=0.
  - vram_we_o=0, vram_d_o=0; starve_o=0, wait_max_o=0; wait counter=0.
  - vram_a_o follows vid_addr_i.
- FSM states: IDLE, PEND, ACCESS.
- IDLE:
  - cpu_rd_req_i or cpu_wr_req_i latches addr, wdata and a write flag, then goes to PEND the next clk.
  - Both requests in the same cycle: the write wins and the read is dropped.
- PEND:
  - On clk_en_acc_i with access_type_i==AC_CPU, go to ACCESS.
  - On clk_en_acc_i with any other access type, the wait counter increments, saturating at 255.
- ACCESS (exactly one slot long):
  - vram_a_o = latched address; vram_d_o = latched wdata.
  - vram_we_o = write flag, registered: it asserts on the clk entering ACCESS and deasserts on the clk leaving it.
  - On the next clk_en_acc_i: a read captures vram_d_i into cpu_rdata_o; cpu_ack_o pulses for one clk; wait_max_o = max(wait_max_o, counter); counter clears; go to IDLE.
- Outside ACCESS: vram_a_o = vid_addr_i (combinational mux), vram_we_o=0.
- cpu_busy_o = (state != IDLE).
- Requests arriving while busy are ignored (no queue). The CPU I/O block must wait for ~cpu_busy_o.
- A request arriving in the ack cycle is ignored, because the state is still ACCESS. It is accepted from the following cycle.
- Fast path: if a slot is already AC_CPU when the request is latched, the access still waits for the next clk_en_acc_i, giving a minimum latency of 2 slots from request to ack.
- starve_o sets when the counter reaches WAIT_LIMIT while in PEND. It stays set until starve_clr_i.
- starve_clr_i has priority over a simultaneous set and over a wait_max_o update.
- Reset mid-ACCESS aborts the access: vram_we_o drops asynchronously and no ack is issued.
- Blank/text mode only changes slot density; no mode input is needed.

Decomposition:
- access_t with AC_CPU is already in vdp18_pkg. Add to vdp18_pkg:
  - cpu_sched_state_t enum {IDLE, PEND, ACCESS};
  - constant VRAM_AW_C = 14.
- Natural sub-module: vdp18_wait_mon (saturating wait counter, max tracker, sticky starve flag).
- The FSM and the VRAM mux stay in the top module.

Test Plan:
- Write: wr_req, addr=14'h3FFF, data=8'hA5; slots STST, PNT, CPU. Required: vram_we_o=1 with vram_a_o=3FFF and vram_d_o=A5 during that slot only; ack one slot later; wait_max_o=2.
- Read: VRAM returns 8'h5C at 14'h0100; access_type_i constantly AC_CPU. Required: cpu_rdata_o=5C, ack 2 slots after the request, vram_we_o never 1.
- Starvation: WAIT_LIMIT=4; 4 non-CPU slots before a CPU slot. Required: starve_o=1 after the 4th slot, held after ack; starve_clr_i then gives starve_o=0 and wait_max_o=0.
- Collision: rd and wr requests in the same cycle, then another request while busy. Required: one write only, one ack; the second request is dropped and cpu_busy_o stays 1 until ack.
- Reset mid-ACCESS: reset_n_i low during a write slot. Required: vram_we_o=0 immediately, no ack, vram_a_o=vid_addr_i.
- Video passthrough: no requests pending, vid_addr_i sweeps values. Required: vram_a_o equals vid_addr_i every cycle.
